// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and types for the data-memory port arbiter
//
// Contents:
//   arb_state_t  : arbiter ownership states ST_IDLE / ST_OWN0 / ST_OWN1
//   PORT0/PORT1  : requester identifiers carried through the read-return pipe
//   DMEM_ADDR_W  : default dmem address width
//   DMEM_DATA_W  : default dmem data width
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DMEM_ADDR_W = 13;
  localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter_rd_return_pipe.sv
// rtl/dmem_arbiter_rd_return_pipe.sv - RD_LAT-deep valid+port-ID pipe that steers read-data strobes
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset, clears all in-flight entries
//   push     in   a read was granted this cycle
//   push_id  in   port that owns the granted read
//   rvalid0  out  read data on mem_data_out belongs to port 0 this cycle
//   rvalid1  out  read data on mem_data_out belongs to port 1 this cycle
module rd_return_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  output logic rvalid0,
  output logic rvalid1
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] id_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= push;
      id_q[0]  <= push_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  // Gating with reset drops a read whose data would land while reset is
  // asserted; the pipe itself is cleared on the same edge.
  assign rvalid0 = vld_q[RD_LAT-1] & (id_q[RD_LAT-1] == PORT0) & ~reset;
  assign rvalid1 = vld_q[RD_LAT-1] & (id_q[RD_LAT-1] == PORT1) & ~reset;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with burst cap for the dmem/MMIO port
//
// Optional build macro: DMEM_ARB_STATS_EN adds per-port stall counters.
//
// Ports:
//   clock, reset                          clock and synchronous active-high reset
//   req0, we0, addr0, wdata0              port 0 (processor load/store) request
//   gnt0, rvalid0, rdata0                 port 0 grant and read return
//   req1, we1, addr1, wdata1              port 1 (auxiliary master) request
//   gnt1, rvalid1, rdata1                 port 1 grant and read return
//   mem_address, mem_data_in, mem_wren    to mmio
//   mem_data_out                          from mmio, valid RD_LAT cycles after a read grant
//   stall_cnt0, stall_cnt1                (DMEM_ARB_STATS_EN) saturating waiting-cycle counts
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1
`endif
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;

  logic       grant_vld;
  logic       grant_id;
  logic       rd_push;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= PORT1;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Grant decision: a lone requester always wins; under contention the
  // owner keeps the port until its burst count reaches the cap.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = PORT0;
    if (!reset) begin
      case ({req1, req0})
        2'b01: begin
          grant_vld = 1'b1;
          grant_id  = PORT0;
        end
        2'b10: begin
          grant_vld = 1'b1;
          grant_id  = PORT1;
        end
        2'b11: begin
          grant_vld = 1'b1;
          if (state_q == ST_OWN0) begin
            grant_id = (burst_q < MAX_BURST_C) ? PORT0 : PORT1;
          end else if (state_q == ST_OWN1) begin
            grant_id = (burst_q < MAX_BURST_C) ? PORT1 : PORT0;
          end else begin
            grant_id = ~last_q;
          end
        end
        default: begin
          grant_vld = 1'b0;
        end
      endcase
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    if (grant_vld) begin
      state_d = (grant_id == PORT0) ? ST_OWN0 : ST_OWN1;
      last_d  = grant_id;
      if (grant_id != last_q) begin
        burst_d = 4'd1;
      end else if (burst_q != 4'hF) begin
        burst_d = burst_q + 4'd1;
      end
    end else begin
      state_d = ST_IDLE;
      burst_d = 4'd0;
    end
  end

  // Outputs
  always_comb begin
    gnt0        = grant_vld & (grant_id == PORT0);
    gnt1        = grant_vld & (grant_id == PORT1);
    mem_address = '0;
    mem_data_in = '0;
    mem_wren    = 1'b0;
    if (gnt0) begin
      mem_address = addr0;
      mem_data_in = wdata0;
      mem_wren    = we0;
    end else if (gnt1) begin
      mem_address = addr1;
      mem_data_in = wdata1;
      mem_wren    = we1;
    end
  end

  assign rd_push = (gnt0 & ~we0) | (gnt1 & ~we1);

  rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clock   (clock),
    .reset   (reset),
    .push    (rd_push),
    .push_id (grant_id),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1)
  );

  assign rdata0 = rvalid0 ? mem_data_out : '0;
  assign rdata1 = rvalid1 ? mem_data_out : '0;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt0 <= 16'd0;
      stall_cnt1 <= 16'd0;
    end else begin
      if (req0 && !gnt0 && stall_cnt0 != 16'hFFFF) begin
        stall_cnt0 <= stall_cnt0 + 16'd1;
      end
      if (req1 && !gnt1 && stall_cnt1 != 16'hFFFF) begin
        stall_cnt1 <= stall_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_data_out;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]       stall_cnt0, stall_cnt1;
`endif

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_wren(mem_wren), .mem_data_out(mem_data_out)
`ifdef DMEM_ARB_STATS_EN
    , .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
  );

  // Behavioural mmio: one-cycle registered read, write on the clock edge.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mmem [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] pattern(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  always @(posedge clock) begin
    mem_data_out <= mem[mem_address];
    if (mem_wren) mem[mem_address] = mem_data_in;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic req0;
    logic req1;
    logic g0;
    logic g1;
  } vec_t;

  typedef struct {
    int               port;
    logic [DATA_W-1:0] data;
    int               due;
  } rd_t;

  vec_t tbl[15];
  rd_t  rq[$];

  // Reference model state for the random phase
  int   m_last, m_run, eg;
  bit   m_idle;
  bit   pq[2], pwe[2];
  logic [ADDR_W-1:0] pa[2];
  logic [DATA_W-1:0] pd[2];
  bit   rst_r;
  logic exp_rv0, exp_rv1;
  logic [DATA_W-1:0] exp_rd0, exp_rd1, exp_ad, exp_di;
  logic exp_we;
  int   ms0, ms1;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pattern(i);

    // Test 1: reset with both ports requesting
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_wren", 32'(mem_wren), 32'd0);
      chk("rst_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
      chk("rst_rdata", rdata0 | rdata1, 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("first_gnt0", 32'(gnt0), 32'd1);
    chk("first_gnt1", 32'(gnt1), 32'd0);
    @(posedge clock); #1;
    do_reset();

    // Test 2: port 0 write then read back
    req0 = 1'b1; we0 = 1'b1; addr0 = 13'h010; wdata0 = 32'hDEADBEEF;
    @(negedge clock);
    chk("wr_gnt0", 32'(gnt0), 32'd1);
    chk("wr_wren", 32'(mem_wren), 32'd1);
    chk("wr_addr", 32'(mem_address), 32'h010);
    chk("wr_data", mem_data_in, 32'hDEADBEEF);
    @(posedge clock); #1;
    we0 = 1'b0;
    @(negedge clock);
    chk("rd_gnt0", 32'(gnt0), 32'd1);
    chk("rd_wren", 32'(mem_wren), 32'd0);
    chk("rd_rvalid0_early", 32'(rvalid0), 32'd0);
    @(posedge clock); #1;
    req0 = 1'b0;
    @(negedge clock);
    chk("rd_rvalid0", 32'(rvalid0), 32'd1);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd_rvalid1", 32'(rvalid1), 32'd0);
    chk("idle_addr", 32'(mem_address), 32'd0);
    chk("idle_data", mem_data_in, 32'd0);
    chk("idle_wren", 32'(mem_wren), 32'd0);
    @(posedge clock); #1;
    chk("rd_rvalid0_pulse", 32'(rvalid0), 32'd0);
    do_reset();

    // Test 3: table of contention patterns (writes, so no read returns)
    for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b1, (i < 4 || i >= 8), (i >= 4 && i < 8)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 15; i++) begin
      req0 = tbl[i].req0; req1 = tbl[i].req1; we0 = 1'b1; we1 = 1'b1;
      addr0 = 13'h1F00 + 13'(i); addr1 = 13'h1E00 + 13'(i);
      wdata0 = 32'h1000 + 32'(i); wdata1 = 32'h2000 + 32'(i);
      @(negedge clock);
      chk($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_address),
          tbl[i].g0 ? 32'(addr0) : (tbl[i].g1 ? 32'(addr1) : 32'd0));
      chk($sformatf("tbl%0d_wren", i), 32'(mem_wren), 32'(tbl[i].g0 | tbl[i].g1));
      @(posedge clock); #1;
    end
    do_reset();

    // Test 4: alternating single-port reads on consecutive cycles
    for (int k = 0; k < 5; k++) begin
      req0 = (k < 4) && (k % 2 == 0);
      req1 = (k < 4) && (k % 2 == 1);
      we0 = 1'b0; we1 = 1'b0;
      addr0 = 13'h100 + 13'(k); addr1 = 13'h100 + 13'(k);
      @(negedge clock);
      if (k < 4) chk($sformatf("alt%0d_gnt", k), 32'((k % 2 == 0) ? gnt0 : gnt1), 32'd1);
      if (k >= 1) begin
        chk($sformatf("alt%0d_rv0", k), 32'(rvalid0), 32'((k - 1) % 2 == 0));
        chk($sformatf("alt%0d_rv1", k), 32'(rvalid1), 32'((k - 1) % 2 == 1));
        chk($sformatf("alt%0d_rdata", k), ((k - 1) % 2 == 0) ? rdata0 : rdata1,
            pattern(32'h100 + k - 1));
      end
      @(posedge clock); #1;
    end
    do_reset();

    // Test 5: reset one cycle after a granted port 1 read
    req1 = 1'b1; we1 = 1'b0; addr1 = 13'h123;
    @(negedge clock);
    chk("rr_gnt1", 32'(gnt1), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1; req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rr_rv1_%0d", i), 32'(rvalid1), 32'd0);
      @(posedge clock); #1;
    end
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    @(negedge clock);
    chk("rr_tie_gnt0", 32'(gnt0), 32'd1);
    chk("rr_tie_gnt1", 32'(gnt1), 32'd0);
    chk("rr_rv1_after", 32'(rvalid1), 32'd0);
    @(posedge clock); #1;
    do_reset();

    // Random phase against the reference model
    for (int i = 0; i < (1 << ADDR_W); i++) mmem[i] = mem[i];
    m_last = 1; m_run = 0; m_idle = 1'b1; ms0 = 0; ms1 = 0;
    pq[0] = 1'b0; pq[1] = 1'b0;
    rq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_r = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!pq[p] && $urandom_range(0, 99) < 60) begin
          pq[p]  = 1'b1;
          pwe[p] = 1'($urandom_range(0, 1));
          pa[p]  = 13'($urandom_range(0, 15));
          pd[p]  = $urandom;
        end
      end
      reset = rst_r;
      req0 = pq[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
      req1 = pq[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
      @(negedge clock);

      if (rst_r)               eg = -1;
      else if (pq[0] && pq[1]) eg = m_idle ? (1 - m_last) : ((m_run < MAX_BURST) ? m_last : (1 - m_last));
      else if (pq[0])          eg = 0;
      else if (pq[1])          eg = 1;
      else                     eg = -1;

      exp_we = (eg >= 0) ? pwe[eg] : 1'b0;
      exp_ad = (eg >= 0) ? 32'(pa[eg]) : 32'd0;
      exp_di = (eg >= 0) ? pd[eg] : 32'd0;
      exp_rv0 = !rst_r && rq.size() > 0 && rq[0].due == cyc && rq[0].port == 0;
      exp_rv1 = !rst_r && rq.size() > 0 && rq[0].due == cyc && rq[0].port == 1;
      exp_rd0 = exp_rv0 ? rq[0].data : 32'd0;
      exp_rd1 = exp_rv1 ? rq[0].data : 32'd0;

      chk("rnd_gnt0", 32'(gnt0), 32'(eg == 0));
      chk("rnd_gnt1", 32'(gnt1), 32'(eg == 1));
      chk("rnd_wren", 32'(mem_wren), 32'(exp_we));
      chk("rnd_addr", 32'(mem_address), exp_ad);
      chk("rnd_wdata", mem_data_in, exp_di);
      chk("rnd_rv0", 32'(rvalid0), 32'(exp_rv0));
      chk("rnd_rv1", 32'(rvalid1), 32'(exp_rv1));
      chk("rnd_rdata0", rdata0, exp_rd0);
      chk("rnd_rdata1", rdata1, exp_rd1);

      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (rst_r) begin
        m_last = 1; m_run = 0; m_idle = 1'b1; ms0 = 0; ms1 = 0;
        rq.delete();
      end else begin
        if (pq[0] && eg != 0 && ms0 < 65535) ms0++;
        if (pq[1] && eg != 1 && ms1 < 65535) ms1++;
        if (eg >= 0) begin
          m_run  = (m_idle || eg != m_last) ? ((eg != m_last) ? 1 : m_run + 1) : ((m_run < 15) ? m_run + 1 : 15);
          m_last = eg;
          m_idle = 1'b0;
          if (pwe[eg]) mmem[pa[eg]] = pd[eg];
          else         rq.push_back('{eg, mmem[pa[eg]], cyc + RD_LAT});
          pq[eg] = 1'b0;
        end else begin
          m_idle = 1'b1;
          m_run  = 0;
        end
      end
      @(posedge clock); #1;
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stall_cnt0", 32'(stall_cnt0), 32'(ms0));
    chk("stall_cnt1", 32'(stall_cnt1), 32'(ms1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
